// File: rtl/regfile_flags.sv
// Architectural register file with two combinational read ports, ALU and load write ports,
// and registered carry/zero flags. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module regfile_flags #(
    parameter int DATA_BITS = 8,
    parameter int NUM_REGS  = 16,
    localparam int ADDR_BITS = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] rd_addr_a,
    output logic [DATA_BITS-1:0] rd_data_a,
    input  logic [ADDR_BITS-1:0] rd_addr_b,
    output logic [DATA_BITS-1:0] rd_data_b,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 ld_en,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [DATA_BITS-1:0] ld_data,
    input  logic                 flags_we,
    input  logic                 carry_in,
    input  logic                 zero_in,
    output logic                 carry_flag,
    output logic                 zero_flag
);

    // One extra bit so NUM_REGS itself is representable when it is a power of two.
    localparam logic [ADDR_BITS:0] REG_LIMIT = (ADDR_BITS + 1)'(NUM_REGS);

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic                 carry_q;
    logic                 zero_q;

    logic wr_ok;
    logic ld_ok;
    logic ld_commit;
    logic rda_ok;
    logic rdb_ok;

    always_comb begin
        wr_ok     = wr_en && ({1'b0, wr_addr} < REG_LIMIT);
        ld_ok     = ld_en && ({1'b0, ld_addr} < REG_LIMIT);
        // ALU port owns a shared address; the load data is dropped.
        ld_commit = ld_ok && !(wr_ok && (wr_addr == ld_addr));
        rda_ok    = reset_n && ({1'b0, rd_addr_a} < REG_LIMIT);
        rdb_ok    = reset_n && ({1'b0, rd_addr_b} < REG_LIMIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_commit) begin
                regs[ld_addr] <= ld_data;
            end
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (flags_we) begin
            carry_q <= carry_in;
            zero_q  <= zero_in;
        end
    end

    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

    always_comb begin
        rd_data_a = '0;
        if (rda_ok) begin
            rd_data_a = regs[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else if (ld_ok && (ld_addr == rd_addr_a)) begin
                rd_data_a = ld_data;
            end
`endif
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rdb_ok) begin
            rd_data_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else if (ld_ok && (ld_addr == rd_addr_b)) begin
                rd_data_b = ld_data;
            end
`endif
        end
    end

endmodule
